usb_tx_encoder: RTL

- Full-speed USB 1.0 transmit line encoder; mirror of the receiver's decode path.
- Accepts packet bytes over a valid/ready handshake and emits a complete line packet on D+/D-:
  - SYNC
  - NRZI-encoded, bit-stuffed data
  - EOP
- An internal bit-period counter sets line timing, equivalent to the receiver's flex counter run as a divider.
- Sits between the transmit packet builder (PID/CRC) and the bus driver.

---
 rtl/usb_tx_encoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB transmit line encoder producing SYNC, NRZI bit-stuffed data and EOP on D+/D-.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0] bitn, bitn_n, ones, ones_n, ob;
    logic [7:0] shreg;
    logic [1:0] line, line_n;
    logic last, pend, pend_n, fin, fin_n, load, wrap, b, nb, eob, fl;
    assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
    assign tx_active = state != IDLE;
    assign {dplus_out, dminus_out} = line;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bitn <= '0;
            ones <= '0;
            shreg <= '0;
            last <= 1'b0;
            pend <= 1'b0;
            fin <= 1'b0;
            line <= 2'b10;
            tx_done <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= (state == IDLE || wrap) ? '0 : cnt + CW'(1);
            bitn <= bitn_n;
            ones <= ones_n;
            pend <= pend_n;
            fin <= fin_n;
            if (load) begin
                shreg <= tx_data;
                last <= tx_last;
            end
            if (state == IDLE ? tx_valid : wrap)
                line <= line_n;
            tx_done <= state == EOP_J && wrap;
        end
    end
    // pend: a byte load is owed once the stuff bit ends; fin: EOP follows the stuff bit
    always_comb begin
        state_n = state;
        bitn_n = bitn;
        ones_n = ones;
        pend_n = pend;
        fin_n = fin;
        tx_ready = 1'b0;
        tx_err = 1'b0;
        load = 1'b0;
        b = state == SYNC ? bitn == 3'd7 : shreg[bitn];
        ob = b ? ones + 3'd1 : 3'd0;
        eob = bitn == 3'd7;
        fl = state == DATA && last;
        case (state)
            IDLE: if (tx_valid) begin
                state_n = SYNC;
                bitn_n = '0;
                ones_n = '0;
            end
            SYNC, DATA: if (wrap) begin
                if (ob == 3'd6) begin
                    state_n = STUFF;
                    ones_n = '0;
                    bitn_n = bitn + 3'd1;
                    pend_n = eob && !fl;
                    fin_n = eob && fl;
                end else begin
                    ones_n = ob;
                    if (eob && fl)
                        state_n = EOP_SE0;
                    else if (eob)
                        tx_ready = 1'b1;
                    else
                        bitn_n = bitn + 3'd1;
                end
            end
            STUFF: if (wrap) begin
                if (fin)
                    state_n = EOP_SE0;
                else if (pend)
                    tx_ready = 1'b1;
                else
                    state_n = DATA;
            end
            EOP_SE0: if (wrap) begin
                bitn_n = bitn + 3'd1;
                state_n = bitn[0] ? EOP_J : EOP_SE0;
            end
            EOP_J: if (wrap) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (tx_ready) begin
            load = tx_valid;
            tx_err = !tx_valid;
            state_n = tx_valid ? DATA : EOP_SE0;
            bitn_n = '0;
        end
        if (state_n == EOP_SE0 && state != EOP_SE0)
            bitn_n = '0;
        nb = state_n == SYNC ? bitn_n == 3'd7 : state_n == DATA ? (load ? tx_data[0] : shreg[bitn_n]) : 1'b0;
        line_n = state_n == EOP_SE0 ? 2'b00 : (state_n == EOP_J || state_n == IDLE) ? 2'b10 : nb ? line : ~line;
    end
endmodule
